// File: rtl/psys_route_scheduler.sv
// Packet-granting arbiter feeding the 1536->6144 packer: whole packets, zero-padded to GROUP beats.
// Define PSYS_SCHED_WEIGHT_PRIO_EN for strict weight-source priority; round-robin otherwise.
module psys_route_scheduler #(
  parameter int unsigned DATA_W = 1536,
  parameter int unsigned GROUP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic              s0_axis_tlast,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic              s1_axis_tlast,
  input  logic              weight_switch_req,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              m_axis_weight_switch,
  output logic              busy
);

  localparam int unsigned      POS_W    = $clog2(GROUP);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(GROUP - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;
  localparam logic [1:0] ST_PAD    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             last_src_q, last_src_d;
  logic             ws_pending_q, ws_pending_d;
  logic             pkt_ws_q, pkt_ws_d;
  logic             win;
  logic             m_hs;

`ifdef PSYS_SCHED_WEIGHT_PRIO_EN
  assign win = ~s0_axis_tvalid;
`else
  // On a tie the source that did not win last time is granted.
  assign win = s1_axis_tvalid & (~s0_axis_tvalid | ~last_src_q);
`endif

  assign m_hs = m_axis_tvalid & m_axis_tready;
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    m_axis_tdata         = '0;
    m_axis_tvalid        = 1'b0;
    m_axis_tlast         = 1'b0;
    s0_axis_tready       = 1'b0;
    s1_axis_tready       = 1'b0;
    m_axis_weight_switch = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        m_axis_tdata         = s0_axis_tdata;
        m_axis_tvalid        = s0_axis_tvalid;
        m_axis_tlast         = s0_axis_tlast;
        s0_axis_tready       = m_axis_tready;
        m_axis_weight_switch = pkt_ws_q;
      end
      ST_GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
      ST_PAD: begin
        m_axis_tvalid        = 1'b1;
        m_axis_weight_switch = pkt_ws_q & ~last_src_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    last_src_d   = last_src_q;
    ws_pending_d = ws_pending_q;
    pkt_ws_d     = pkt_ws_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid | s1_axis_tvalid) begin
          state_d    = win ? ST_GRANT1 : ST_GRANT0;
          pos_d      = '0;
          last_src_d = win;
          if (!win) begin
            pkt_ws_d     = ws_pending_q;
            ws_pending_d = 1'b0;
          end else begin
            pkt_ws_d = 1'b0;
          end
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (m_hs) begin
          pos_d = pos_q + POS_W'(1);
          if (m_axis_tlast) state_d = (pos_q == POS_LAST) ? ST_IDLE : ST_PAD;
        end
      end
      ST_PAD: begin
        if (m_hs) begin
          pos_d = pos_q + POS_W'(1);
          if (pos_q == POS_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A request coinciding with capture survives for the next weight packet.
    if (weight_switch_req) ws_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pos_q        <= '0;
      last_src_q   <= 1'b1;
      ws_pending_q <= 1'b0;
      pkt_ws_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      last_src_q   <= last_src_d;
      ws_pending_q <= ws_pending_d;
      pkt_ws_q     <= pkt_ws_d;
    end
  end

endmodule

// File: tb/tb_psys_route_scheduler.sv
// Self-checking bench for psys_route_scheduler: packet-level reference model, directed and random phases.
module tb_psys_route_scheduler;

  localparam int unsigned DATA_W = 1536;
  localparam int unsigned GROUP  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic              s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic              s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic              weight_switch_req;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic              m_axis_weight_switch, busy;

  psys_route_scheduler #(.DATA_W(DATA_W), .GROUP(GROUP)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s0_axis_tdata       (s0_axis_tdata),
    .s0_axis_tvalid      (s0_axis_tvalid),
    .s0_axis_tready      (s0_axis_tready),
    .s0_axis_tlast       (s0_axis_tlast),
    .s1_axis_tdata       (s1_axis_tdata),
    .s1_axis_tvalid      (s1_axis_tvalid),
    .s1_axis_tready      (s1_axis_tready),
    .s1_axis_tlast       (s1_axis_tlast),
    .weight_switch_req   (weight_switch_req),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready),
    .m_axis_weight_switch(m_axis_weight_switch),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic pad;
    logic src;
    logic ws;
    logic first;
  } ent_t;

  beat_t q0[$];
  beat_t q1[$];
  ent_t  expq[$];
  logic  rdy_pat[$];
  int    grants[$];
  int    exp_order[4];

  logic        v0 = 1'b0, v1 = 1'b0;
  logic        gap_en = 1'b0;
  int unsigned rdy_mode = 0;
  logic        ws_req_nx = 1'b0;
  logic        last_src_m = 1'b1;
  logic        ws_pend_m = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic load(input int src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = rand_data();
      b.last = (i == n - 1);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  function automatic int pkt_len(input int src);
    int n = 0;
    if (src == 0) begin
      foreach (q0[i]) begin n++; if (q0[i].last) break; end
    end else begin
      foreach (q1[i]) begin n++; if (q1[i].last) break; end
    end
    return n;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later, advance the model.
  task automatic step();
    logic              rdy, req, exp_v, exp_r0, exp_r1, exp_l, exp_ws, exp_busy;
    logic [DATA_W-1:0] exp_d;
    ent_t              e;
    int                win, n, tot, obs_src;
    logic              pw;
    if (q0.size() == 0) v0 = 1'b0; else if (!v0) v0 = !gap_en || ($urandom_range(3) != 0);
    if (q1.size() == 0) v1 = 1'b0; else if (!v1) v1 = !gap_en || ($urandom_range(3) != 0);
    if (rdy_pat.size() != 0) rdy = rdy_pat.pop_front();
    else if (rdy_mode == 1)  rdy = ($urandom_range(3) != 0);
    else                     rdy = 1'b1;
    req               = ws_req_nx;
    ws_req_nx         = 1'b0;
    s0_axis_tvalid    = v0;
    s0_axis_tdata     = (q0.size() != 0) ? q0[0].data : '0;
    s0_axis_tlast     = (q0.size() != 0) ? q0[0].last : 1'b0;
    s1_axis_tvalid    = v1;
    s1_axis_tdata     = (q1.size() != 0) ? q1[0].data : '0;
    s1_axis_tlast     = (q1.size() != 0) ? q1[0].last : 1'b0;
    m_axis_tready     = rdy;
    weight_switch_req = req;
    #1;
    exp_v = 1'b0; exp_r0 = 1'b0; exp_r1 = 1'b0; exp_l = 1'b0; exp_ws = 1'b0;
    exp_d = '0;   exp_busy = 1'b0;
    e     = '0;
    if (expq.size() != 0) begin
      e        = expq[0];
      exp_busy = 1'b1;
      exp_ws   = e.ws;
      if (e.pad) begin
        exp_v = 1'b1;
      end else if (e.src == 1'b0) begin
        exp_v = v0; exp_d = q0[0].data; exp_l = q0[0].last; exp_r0 = rdy;
      end else begin
        exp_v = v1; exp_d = q1[0].data; exp_l = q1[0].last; exp_r1 = rdy;
      end
    end
    chk("m_tvalid", m_axis_tvalid, exp_v);
    chk("s0_tready", s0_axis_tready, exp_r0);
    chk("s1_tready", s1_axis_tready, exp_r1);
    chk("weight_switch", m_axis_weight_switch, exp_ws);
    chk("busy", busy, exp_busy);
    if (exp_v) begin
      chk("m_tdata", m_axis_tdata, exp_d);
      chk("m_tlast", m_axis_tlast, exp_l);
    end
    obs_src = s1_axis_tready ? 1 : (s0_axis_tready ? 0 : -1);
    if (expq.size() != 0) begin
      if (exp_v && rdy) begin
        void'(expq.pop_front());
        if (!e.pad) begin
          if (e.first) grants.push_back(obs_src);
          if (e.src == 1'b0) begin void'(q0.pop_front()); v0 = 1'b0; end
          else               begin void'(q1.pop_front()); v1 = 1'b0; end
        end
      end
    end else if (v0 || v1) begin
`ifdef PSYS_SCHED_WEIGHT_PRIO_EN
      win = v0 ? 0 : 1;
`else
      win = (v0 && v1) ? (last_src_m ? 0 : 1) : (v1 ? 1 : 0);
`endif
      last_src_m = (win == 1);
      pw = 1'b0;
      if (win == 0) begin pw = ws_pend_m; ws_pend_m = 1'b0; end
      n   = pkt_len(win);
      tot = ((n + GROUP - 1) / GROUP) * GROUP;
      for (int i = 0; i < tot; i++) begin
        e.pad   = (i >= n);
        e.src   = (win == 1);
        e.ws    = pw;
        e.first = (i == 0);
        expq.push_back(e);
      end
    end
    if (req) ws_pend_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0) && c < budget) begin
      step();
      c++;
    end
    chk("drain_in_budget", (c < budget), 1'b1);
  endtask

  task automatic check_all_reset(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
    chk({tag, "_tdata"}, m_axis_tdata, '0);
    chk({tag, "_ws"}, m_axis_weight_switch, 1'b0);
    chk({tag, "_s0_tready"}, s0_axis_tready, 1'b0);
    chk({tag, "_s1_tready"}, s1_axis_tready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int unsigned c;
`ifdef PSYS_SCHED_WEIGHT_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    s0_axis_tdata = '0; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    s1_axis_tdata = '0; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    weight_switch_req = 1'b0; m_axis_tready = 1'b1;
    @(negedge clk); @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 4-beat weight packet, no padding
    grants.delete();
    load(0, 4);
    drain(40);
    chk("single_w_grant_cnt", grants.size(), 1);
    if (grants.size() != 0) chk("single_w_grant", grants[0], 0);

    // 5-beat feature packet, padded to 8
    load(1, 5);
    drain(40);

    // both sources back to back
    grants.delete();
    for (int i = 0; i < 4; i++) begin load(0, 4); load(1, 4); end
    drain(200);
    chk("rr_grant_cnt", grants.size(), 8);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("grant_order_%0d", i), grants[i], exp_order[i]);

    // weight switch: flagged packet, then feature and plain weight packet
    ws_req_nx = 1'b1;
    step();
    load(0, 4); drain(40);
    load(1, 4); drain(40);
    load(0, 4); drain(40);

    // backpressure during 2-beat packet plus padding
    load(0, 2);
    step();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    drain(40);

    // reset while padding a weight packet
    load(0, 5);
    c = 0;
    while (!(expq.size() != 0 && expq[0].pad) && c < 40) begin step(); c++; end
    chk("reached_pad", (c < 40), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_reset("async_reset");
    q0.delete(); q1.delete(); expq.delete();
    v0 = 1'b0; v1 = 1'b0; last_src_m = 1'b1; ws_pend_m = 1'b0;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; weight_switch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    grants.delete();
    load(0, 4); load(1, 4);
    drain(60);
    chk("post_reset_grant_cnt", grants.size(), 2);
    if (grants.size() != 0) chk("post_reset_first_grant", grants[0], 0);

    // randomized traffic
    gap_en = 1'b1; rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(2) == 0) load(0, int'($urandom_range(9, 1)));
      if (q1.size() == 0 && $urandom_range(2) == 0) load(1, int'($urandom_range(9, 1)));
      ws_req_nx = ($urandom_range(9) == 0);
      step();
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
